equihash_mem_arbiter: RTL and testbench
=======================================

Name: equihash_mem_arbiter

Overview:
- Shares the single external memory command port between the equihash engines: blake2b writer, radix sorter, collision unit and UART/host readback.
- Round-robin arbitration at burst granularity, with one outstanding burst at a time.
- Includes a completion watchdog and a synchronous flush driven by the top-level state controller on run abort or return to idle.
- Sits between the engines and the memory controller, beside the stage sequencer.

Parameters:
NUM_REQ, 4, number of requesters (index 0 = UART/host, 1 = blake2b, 2 = radix, 3 = collision)
ADDR_W, 24, memory address width (tie to MEM_ADDR_WIDTH)
LEN_W, 4, burst length field width; value encodes beats-1
TIMEOUT, 1023, maximum cycles waiting for mem_done before error

Ports:
eclk  in  1  clock
rstb  in  1  reset, asynchronous, active-low
req  in  NUM_REQ  per-requester burst request, level
req_wr  in  NUM_REQ  per-requester write(1)/read(0)
req_addr  in  NUM_REQ*ADDR_W  per-requester start address, packed, requester i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  per-requester beats-1, packed likewise
gnt  out  NUM_REQ  one-cycle pulse: command accepted by memory
done  out  NUM_REQ  one-cycle pulse: burst completed
mem_cmd_valid  out  1  command valid to memory controller
mem_cmd_ready  in  1  memory controller accepts command
mem_cmd_wr  out  1  latched write flag
mem_cmd_addr  out  ADDR_W  latched address
mem_cmd_len  out  LEN_W  latched beats-1
mem_done  in  1  single-cycle pulse: current burst finished
flush  in  1  synchronous abort (from state controller)
owner  out  2  index of current/last granted requester
busy  out  1  high in ISSUE or WAIT
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rstb low, async): state IDLE, rr_ptr=0, owner=0, gnt=0, done=0, mem_cmd_valid=0, mem_cmd_wr/addr/len=0, busy=0, err_timeout=0, watchdog=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req and not flush: pick the first set req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch that requester's wr/addr/len into mem_cmd_*, set owner, go ISSUE.
  - mem_cmd_valid rises the cycle after the req is sampled (latency 1).
  - If flush: stay IDLE, rr_ptr<=0.
- ISSUE:
  - mem_cmd_valid and the mem_cmd_* fields are held stable until mem_cmd_ready.
  - On the valid&&ready cycle: mem_cmd_valid<=0, gnt[owner] pulses next cycle, watchdog<=0, go WAIT.
  - flush with no handshake in the same cycle: drop valid, go IDLE, no gnt.
  - flush and handshake in the same cycle: handshake wins; go WAIT in flushed mode.
- WAIT:
  - Watchdog increments each cycle.
  - On mem_done: done[owner] pulses next cycle (suppressed if flushed mode), rr_ptr<=owner+1 mod NUM_REQ, go IDLE.
  - flush in WAIT: sets flushed mode; the arbiter still waits for mem_done because an in-flight burst cannot be aborted.
  - Watchdog reaching TIMEOUT: err_timeout<=1 and state is forced to IDLE with no done pulse. err_timeout clears only on flush or reset.
- Requester contract:
  - Hold req and its fields stable until gnt.
  - Drop req in the cycle after gnt unless it has another burst.
  - req[owner] is ignored outside IDLE.
  - Deasserting req before gnt is a protocol error; the already-latched command still issues.
- A mem_done outside WAIT is ignored.
- Only one gnt and one done bit can be high in any cycle.
- Back-to-back throughput: done pulse cycle = IDLE cycle, so the next mem_cmd_valid comes 2 cycles after mem_done.
- LEN_W fields pass through unchanged; no address arithmetic is done.
- owner holds its value after completion until the next arbitration.

Test Plan:
- Single request: req[2]=1, addr=0x000100, len=7, wr=0, ready tied 1 -> mem_cmd_valid 1 cycle later with addr 0x000100/len 7; gnt[2] pulse; mem_done -> done[2] pulse next cycle; busy low after.
- Round-robin: req=4'b1111 held continuously, immediate ready/done -> grant order 0,1,2,3,0; no requester granted twice before the others.
- Backpressure: mem_cmd_ready low 5 cycles -> valid/addr/len stable all 5 cycles; exactly one gnt, in the cycle after ready rises.
- Flush: flush in ISSUE -> valid drops, no gnt, rr_ptr=0. Flush in WAIT -> mem_done gives no done pulse, return to IDLE.
- Watchdog: TIMEOUT=15, mem_done never arrives -> err_timeout=1 at WAIT cycle 15, state IDLE, no done; flush clears err_timeout.
- Async reset mid-WAIT: rstb low -> all outputs 0 immediately without a clock edge; after release, first arbitration starts from requester 0.

Source files
------------

// File: rtl/equihash_mem_arbiter.sv
// Round-robin arbiter sharing the external memory command port between the equihash engines.
// One burst outstanding at a time, with a completion watchdog and a synchronous flush.
module equihash_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                      eclk,
    input  logic                      rstb,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_wr,
    output logic [ADDR_W-1:0]         mem_cmd_addr,
    output logic [LEN_W-1:0]          mem_cmd_len,
    input  logic                      mem_done,
    input  logic                      flush,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [1:0]                dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_owner;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_valid;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic                r_busy;
    logic                r_err;
    logic [WD_W-1:0]     r_wdog;
    logic                r_flushed;

    state_t              w_state_nxt;
    logic [1:0]          w_rr_nxt;
    logic [1:0]          w_owner_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic                w_valid_nxt;
    logic                w_wr_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    w_len_nxt;
    logic                w_err_nxt;
    logic [WD_W-1:0]     w_wdog_nxt;
    logic                w_flushed_nxt;

    logic                w_found;
    logic [1:0]          w_pick;
    logic [2:0]          w_sum;
    logic [1:0]          w_owner_inc;

    // Scan from r_rr_ptr upwards with wrap; the first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_sum   = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + 3'(i);
            if (w_sum >= 3'(NUM_REQ)) begin
                w_sum = w_sum - 3'(NUM_REQ);
            end
            if (!w_found && req[w_sum[1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[1:0];
            end
        end
    end

    assign w_owner_inc = (r_owner == 2'(NUM_REQ - 1)) ? 2'd0 : r_owner + 2'd1;

    // Command handshake: mem_cmd_valid and the mem_cmd_* fields stay stable until a cycle
    // with mem_cmd_valid && mem_cmd_ready; that cycle transfers exactly one burst command.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_owner_nxt   = r_owner;
        w_gnt_nxt     = '0;
        w_done_nxt    = '0;
        w_valid_nxt   = r_valid;
        w_wr_nxt      = r_wr;
        w_addr_nxt    = r_addr;
        w_len_nxt     = r_len;
        w_err_nxt     = r_err & ~flush;
        w_wdog_nxt    = r_wdog;
        w_flushed_nxt = r_flushed;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt   = 1'b0;
                w_flushed_nxt = 1'b0;
                if (flush) begin
                    w_rr_nxt = 2'd0;
                end else if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_wr_nxt    = req_wr[w_pick];
                    w_addr_nxt  = req_addr[w_pick*ADDR_W +: ADDR_W];
                    w_len_nxt   = req_len[w_pick*LEN_W +: LEN_W];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_cmd_ready) begin
                    // A flush racing the handshake loses; the burst is already committed.
                    w_valid_nxt        = 1'b0;
                    w_gnt_nxt[r_owner] = 1'b1;
                    w_wdog_nxt         = '0;
                    w_flushed_nxt      = flush;
                    w_state_nxt        = ST_WAIT;
                end else if (flush) begin
                    w_valid_nxt = 1'b0;
                    w_rr_nxt    = 2'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (flush) begin
                    w_flushed_nxt = 1'b1;
                end
                if (mem_done) begin
                    if (!(r_flushed || flush)) begin
                        w_done_nxt[r_owner] = 1'b1;
                    end
                    w_rr_nxt      = w_owner_inc;
                    w_flushed_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_err_nxt     = 1'b1;
                    w_rr_nxt      = w_owner_inc;
                    w_flushed_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge eclk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= 2'd0;
            r_owner   <= 2'd0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_valid   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_wdog    <= '0;
            r_flushed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_owner   <= w_owner_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_valid   <= w_valid_nxt;
            r_wr      <= w_wr_nxt;
            r_addr    <= w_addr_nxt;
            r_len     <= w_len_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_err     <= w_err_nxt;
            r_wdog    <= w_wdog_nxt;
            r_flushed <= w_flushed_nxt;
        end
    end

    assign gnt           = r_gnt;
    assign done          = r_done;
    assign mem_cmd_valid = r_valid;
    assign mem_cmd_wr    = r_wr;
    assign mem_cmd_addr  = r_addr;
    assign mem_cmd_len   = r_len;
    assign owner         = r_owner;
    assign busy          = r_busy;
    assign err_timeout   = r_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_equihash_mem_arbiter.sv
// Bench for equihash_mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_equihash_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 24;
    localparam int LW = 4;
    localparam int TO = 15;

    logic            eclk = 1'b0;
    logic            rstb = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            mem_cmd_valid;
    logic            mem_cmd_ready = 1'b0;
    logic            mem_cmd_wr;
    logic [AW-1:0]   mem_cmd_addr;
    logic [LW-1:0]   mem_cmd_len;
    logic            mem_done = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      owner;
    logic            busy;
    logic            err_timeout;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    equihash_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .eclk(eclk), .rstb(rstb), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .gnt(gnt), .done(done), .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_len(mem_cmd_len), .mem_done(mem_done), .flush(flush), .owner(owner),
        .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 eclk = ~eclk;

    // ---------------- reference model ----------------
    // Tracks the pending command and the in-flight burst as transactions, not as FSM states.
    int            m_rr, m_owner, m_age;
    bit            m_cmd_out, m_in_flight, m_aborted;
    logic          e_wr, e_err;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [N-1:0]  e_gnt, e_done;

    always @(posedge eclk or negedge rstb) begin
        if (!rstb) begin
            m_rr = 0; m_owner = 0; m_age = 0;
            m_cmd_out = 0; m_in_flight = 0; m_aborted = 0;
            e_wr = 0; e_err = 0; e_addr = '0; e_len = '0; e_gnt = '0; e_done = '0;
        end else begin
            e_gnt  = '0;
            e_done = '0;
            if (flush) e_err = 0;
            if (m_in_flight) begin
                m_age = m_age + 1;
                if (flush) m_aborted = 1;
                if (mem_done) begin
                    if (!m_aborted) e_done[m_owner] = 1'b1;
                    m_in_flight = 0;
                    m_rr = (m_owner + 1) % N;
                end else if (m_age == TO) begin
                    e_err = 1;
                    m_in_flight = 0;
                    m_rr = (m_owner + 1) % N;
                end
            end else if (m_cmd_out) begin
                if (mem_cmd_ready) begin
                    m_cmd_out = 0;
                    m_in_flight = 1;
                    m_age = 0;
                    m_aborted = flush;
                    e_gnt[m_owner] = 1'b1;
                end else if (flush) begin
                    m_cmd_out = 0;
                    m_rr = 0;
                end
            end else if (flush) begin
                m_rr = 0;
            end else if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (!m_cmd_out && req[idx]) begin
                        m_cmd_out = 1;
                        m_owner = idx;
                        e_wr = req_wr[idx];
                        e_addr = req_addr[idx*AW +: AW];
                        e_len = req_len[idx*LW +: LW];
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge eclk) begin
        if (rstb) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("done", 32'(done), 32'(e_done));
            chk("valid", 32'(mem_cmd_valid), 32'(m_cmd_out));
            chk("cmd_wr", 32'(mem_cmd_wr), 32'(e_wr));
            chk("cmd_addr", 32'(mem_cmd_addr), 32'(e_addr));
            chk("cmd_len", 32'(mem_cmd_len), 32'(e_len));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("busy", 32'(busy), 32'(m_cmd_out | m_in_flight));
            chk("err_timeout", 32'(err_timeout), 32'(e_err));
            chk("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(m_cmd_out | m_in_flight));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge eclk);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req[i] = 1'b1;
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW] = l;
    endtask

    task automatic new_burst(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 24'hFFFFFF)), LW'($urandom_range(0, 15)));
    endtask

    task automatic apply_reset();
        tick();
        rstb = 1'b0;
        req = '0; flush = 1'b0; mem_done = 1'b0; mem_cmd_ready = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int got;
        int dn_cnt;

        apply_reset();
        tick();
        chk("rst_valid", 32'(mem_cmd_valid), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);

        // single request
        set_req(2, 1'b0, 24'h000100, 4'd7);
        mem_cmd_ready = 1'b1;
        tick();
        chk("sr_valid", 32'(mem_cmd_valid), 32'd1);
        chk("sr_addr", 32'(mem_cmd_addr), 32'h000100);
        chk("sr_len", 32'(mem_cmd_len), 32'd7);
        chk("sr_wr", 32'(mem_cmd_wr), 32'd0);
        chk("sr_owner", 32'(owner), 32'd2);
        tick();
        chk("sr_gnt", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("sr_done", 32'(done), 32'b0100);
        chk("sr_busy_after", 32'(busy), 32'd0);

        // round robin with all requesters held
        apply_reset();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < N; i++) new_burst(i);
        mem_cmd_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
            tick();
            mem_done = 1'b0;
            if (gnt != '0) begin
                got = 0;
                for (int b = 0; b < N; b++) if (gnt[b]) got = b;
                chk("rr_onehot", 32'($countones(gnt)), 32'd1);
                chk("rr_order", 32'(got), 32'(exp_q.pop_front()));
                mem_done = 1'b1;
            end
        end
        chk("rr_all_granted", 32'(exp_q.size()), 32'd0);
        tick();
        mem_done = 1'b0;
        req = '0;
        repeat (2) tick();

        // flush in ISSUE then flush in WAIT (round-robin pointer now at 1)
        set_req(0, 1'b0, 24'h000AAA, 4'd2);
        set_req(3, 1'b1, 24'h333000, 4'd5);
        mem_cmd_ready = 1'b0;
        tick();
        chk("fl_owner_first", 32'(owner), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid_drop", 32'(mem_cmd_valid), 32'd0);
        chk("fl_no_gnt", 32'(gnt), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        tick();
        chk("fl_rr_reset_owner", 32'(owner), 32'd0);
        chk("fl_readdr", 32'(mem_cmd_addr), 32'h000AAA);
        mem_cmd_ready = 1'b1;
        tick();
        chk("flw_gnt", 32'(gnt), 32'b0001);
        mem_cmd_ready = 1'b0;
        req[0] = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        req[3] = 1'b0;
        chk("flw_no_done", 32'(done), 32'd0);
        chk("flw_idle", 32'(busy), 32'd0);
        tick();

        // backpressure: ready low for five ISSUE cycles
        set_req(1, 1'b1, 24'hABCDEF, 4'd3);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(mem_cmd_valid), 32'd1);
            chk("bp_addr", 32'(mem_cmd_addr), 32'hABCDEF);
            chk("bp_len", 32'(mem_cmd_len), 32'd3);
            chk("bp_no_gnt", 32'(gnt), 32'd0);
            tick();
        end
        chk("bp_still_valid", 32'(mem_cmd_valid), 32'd1);
        mem_cmd_ready = 1'b1;
        tick();
        chk("bp_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("bp_done", 32'(done), 32'b0010);

        // watchdog: mem_done never arrives
        set_req(2, 1'b0, 24'h123456, 4'd1);
        tick();
        tick();
        chk("wd_gnt", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        for (int k = 2; k <= TO; k++) begin
            tick();
            chk("wd_err_early", 32'(err_timeout), 32'd0);
            chk("wd_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("wd_err_set", 32'(err_timeout), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_no_done", 32'(done), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("wd_err_cleared", 32'(err_timeout), 32'd0);

        // asynchronous reset in the middle of WAIT
        set_req(1, 1'b1, 24'hFEDCBA, 4'd9);
        tick();
        tick();
        chk("ar_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        #2;
        rstb = 1'b0;
        #1;
        chk("ar_gnt0", 32'(gnt), 32'd0);
        chk("ar_valid0", 32'(mem_cmd_valid), 32'd0);
        chk("ar_wr0", 32'(mem_cmd_wr), 32'd0);
        chk("ar_addr0", 32'(mem_cmd_addr), 32'd0);
        chk("ar_len0", 32'(mem_cmd_len), 32'd0);
        chk("ar_busy0", 32'(busy), 32'd0);
        chk("ar_state0", 32'(dbg_state), 32'd0);
        tick();
        set_req(0, 1'b0, 24'h0000C0, 4'd4);
        set_req(3, 1'b1, 24'h0000C3, 4'd6);
        tick();
        rstb = 1'b1;
        tick();
        chk("ar_first_owner", 32'(owner), 32'd0);
        tick();
        chk("ar_first_gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("ar_done", 32'(done), 32'b0001);

        // random traffic
        dn_cnt = -1;
        repeat (3000) begin
            tick();
            mem_done = 1'b0;
            if (dn_cnt == 0) mem_done = 1'b1;
            else if (dn_cnt < 0 && $urandom_range(0, 40) == 0) mem_done = 1'b1;
            if (dn_cnt >= 0) dn_cnt--;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) new_burst(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    new_burst(i);
                end
            end
            flush = ($urandom_range(0, 50) == 0);
            mem_cmd_ready = ($urandom_range(0, 2) != 0);
            if (mem_cmd_valid && mem_cmd_ready)
                dn_cnt = ($urandom_range(0, 14) == 0) ? 20 : int'($urandom_range(0, 8));
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
